// File: rtl/des_pkg.sv
// Shared DES round types, FIPS 46-3 tables and bit-shuffling helpers.
package des_pkg;

    localparam int unsigned HALF_W = 32;
    localparam int unsigned KEY_W  = 48;
    localparam int unsigned SBOX_N = 8;

    typedef logic [HALF_W-1:0] half_t;
    typedef logic [KEY_W-1:0]  subkey_t;

    localparam int unsigned E_TABLE [KEY_W] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TABLE [HALF_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // One entry per S-box: rows 0..3 back to back, first nibble = row 0 column 0.
    localparam logic [255:0] SBOX_TABLE [SBOX_N] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A628E5CBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // FIPS bit n lives at vector bit [W-n].
    function automatic subkey_t des_expand(input half_t r);
        subkey_t e;
        for (int i = 0; i < KEY_W; i++) begin
            e[KEY_W-1-i] = r[HALF_W - E_TABLE[i]];
        end
        return e;
    endfunction

    function automatic half_t des_perm_p(input half_t s);
        half_t p;
        for (int i = 0; i < HALF_W; i++) begin
            p[HALF_W-1-i] = s[HALF_W - P_TABLE[i]];
        end
        return p;
    endfunction

    // Row from the outer bits, column from the inner four.
    function automatic logic [3:0] des_sbox(input logic [2:0] k, input logic [5:0] b);
        logic [5:0]   idx;
        logic [255:0] t;
        idx = {b[5], b[0], b[4:1]};
        t   = SBOX_TABLE[k] >> {~idx, 2'b00};
        return t[3:0];
    endfunction

endpackage

// File: rtl/des_f_comb.sv
// Combinational DES f core: 48-bit S-box input through s1..s8 and P.
module des_f_comb
    import des_pkg::*;
(
    input  subkey_t x,
    output half_t   f_c
);
    half_t s_out;

    for (genvar k = 0; k < SBOX_N; k++) begin : g_sbox
        assign s_out[HALF_W-1-4*k -: 4] = des_sbox(3'(k), x[KEY_W-1-6*k -: 6]);
    end

    assign f_c = des_perm_p(s_out);

endmodule

// File: rtl/des_round_pipe.sv
// One pipelined DES Feistel round with valid/ready handshake.
// Define DES_ROUND_PARITY_EN to add parity protection of the stored x and the err output.
module des_round_pipe
    import des_pkg::*;
#(
    parameter int unsigned PIPE_MID = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    output logic    in_ready,
    input  half_t   in_l,
    input  half_t   in_r,
    input  subkey_t in_subkey,
    input  logic    in_last,
    output logic    out_valid,
    input  logic    out_ready,
    output half_t   out_l,
    output half_t   out_r
`ifdef DES_ROUND_PARITY_EN
    ,
    output logic    err
`endif
);
    subkey_t x_in;
    assign x_in = des_expand(in_r) ^ in_subkey;

    if (PIPE_MID != 0) begin : g_mid
        logic    valid_a;
        logic    last_a;
        logic    adv_a;
        logic    adv_b;
        subkey_t x_a;
        half_t   l_a;
        half_t   r_a;
        half_t   f_a;
`ifdef DES_ROUND_PARITY_EN
        logic    par_a;
`endif

        assign adv_b    = !out_valid || out_ready;
        assign adv_a    = !valid_a || adv_b;
        assign in_ready = adv_a;

        des_f_comb u_f (
            .x   (x_a),
            .f_c (f_a)
        );

        // Stage A holds the keyed expansion; stage B holds the finished halves.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_a   <= 1'b0;
                last_a    <= 1'b0;
                x_a       <= '0;
                l_a       <= '0;
                r_a       <= '0;
                out_valid <= 1'b0;
                out_l     <= '0;
                out_r     <= '0;
`ifdef DES_ROUND_PARITY_EN
                par_a     <= 1'b0;
                err       <= 1'b0;
`endif
            end else begin
                if (adv_a) begin
                    valid_a <= in_valid;
                    if (in_valid) begin
                        x_a    <= x_in;
                        l_a    <= in_l;
                        r_a    <= in_r;
                        last_a <= in_last;
`ifdef DES_ROUND_PARITY_EN
                        par_a  <= ^x_in;
`endif
                    end
                end
                if (adv_b) begin
                    out_valid <= valid_a;
                    if (valid_a) begin
                        out_l <= last_a ? (l_a ^ f_a) : r_a;
                        out_r <= last_a ? r_a : (l_a ^ f_a);
`ifdef DES_ROUND_PARITY_EN
                        if ((^x_a) != par_a) begin
                            err <= 1'b1;
                        end
`endif
                    end
                end
            end
        end
    end else begin : g_flat
        half_t f_in;

        assign in_ready = !out_valid || out_ready;

        des_f_comb u_f (
            .x   (x_in),
            .f_c (f_in)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid <= 1'b0;
                out_l     <= '0;
                out_r     <= '0;
            end else if (in_ready) begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_l <= in_last ? (in_l ^ f_in) : in_r;
                    out_r <= in_last ? in_r : (in_l ^ f_in);
                end
            end
        end

`ifdef DES_ROUND_PARITY_EN
        assign err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_des_round_pipe.sv
// Bench for des_round_pipe: both pipeline depths side by side against a FIPS-indexed round model.
module tb_des_round_pipe;

    localparam int E_T [1:48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };
    localparam int P_T [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };
    localparam logic [63:0] SB_T [1:8][0:3] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A628E5CBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic        chk;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready0;
    logic [31:0] in_l;
    logic [31:0] in_r;
    logic [47:0] in_k;
    logic        in_last;
    logic        out_ready;
    logic        out_valid;
    logic        out_valid0;
    logic [31:0] out_l;
    logic [31:0] out_r;
    logic [31:0] out_l0;
    logic [31:0] out_r0;
`ifdef DES_ROUND_PARITY_EN
    logic        err;
    logic        err0;
    logic [47:0] x_flip;
`endif

    int   n_cmp;
    int   n_bad;
    int   acc1;
    int   acc0;
    logic took1;
    exp_t q1[$];
    exp_t q0[$];

    des_round_pipe #(.PIPE_MID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_r(in_r), .in_subkey(in_k), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r)
`ifdef DES_ROUND_PARITY_EN
        , .err(err)
`endif
    );

    des_round_pipe #(.PIPE_MID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_l(in_l), .in_r(in_r), .in_subkey(in_k), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_l(out_l0), .out_r(out_r0)
`ifdef DES_ROUND_PARITY_EN
        , .err(err0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook DES f with FIPS 1-based bit numbering.
    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [1:32] rb;
        logic [1:48] x;
        logic [1:48] kb;
        logic [1:32] s;
        logic [1:32] f;
        logic [1:6]  b;
        logic [63:0] v;
        int          row;
        int          col;
        rb = r;
        kb = k;
        for (int i = 1; i <= 48; i++) x[i] = rb[E_T[i]] ^ kb[i];
        for (int j = 1; j <= 8; j++) begin
            for (int m = 1; m <= 6; m++) b[m] = x[6*(j-1)+m];
            row = 2*int'(b[1]) + int'(b[6]);
            col = 8*int'(b[2]) + 4*int'(b[3]) + 2*int'(b[4]) + int'(b[5]);
            v = SB_T[j][row] >> (4*(15-col));
            for (int m = 1; m <= 4; m++) s[4*(j-1)+m] = v[4-m];
        end
        for (int i = 1; i <= 32; i++) f[i] = s[P_T[i]];
        return f;
    endfunction

    function automatic exp_t model(input logic [31:0] l, input logic [31:0] r,
                                   input logic [47:0] k, input logic last);
        exp_t e;
        logic [31:0] f;
        f = f_model(r, k);
        e.l   = last ? (l ^ f) : r;
        e.r   = last ? r : (l ^ f);
        e.chk = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] l, input logic [31:0] r,
                         input logic [47:0] k, input logic last);
        in_valid = v;
        in_l     = l;
        in_r     = r;
        in_k     = k;
        in_last  = last;
    endtask

    task automatic drive_rand();
        drive(1'b1, $urandom(), $urandom(), {16'($urandom()), 32'($urandom())},
              1'($urandom_range(0, 1)));
    endtask

    // Model side of each transfer: retire drained blocks, enqueue accepted ones.
    always @(posedge clk) begin
        took1 = 1'b0;
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            check("in_ready_mid", 64'(in_ready), 64'((q1.size() < 2) || out_ready));
            check("in_ready_flat", 64'(in_ready0), 64'((q0.size() < 1) || out_ready));
            if (out_valid && out_ready && q1.size() > 0) void'(q1.pop_front());
            if (out_valid0 && out_ready && q0.size() > 0) void'(q0.pop_front());
            if (in_valid && in_ready) begin
                q1.push_back(model(in_l, in_r, in_k, in_last));
                acc1++;
                took1 = 1'b1;
            end
            if (in_valid && in_ready0) begin
                q0.push_back(model(in_l, in_r, in_k, in_last));
                acc0++;
            end
        end
    end

    // Output side: every presented block must be the oldest outstanding one.
    always @(negedge clk) begin
        if (q1.size() == 0) check("mid_spurious", 64'(out_valid), 64'(0));
        else if (out_valid && q1[0].chk) check("mid_data", {out_l, out_r}, {q1[0].l, q1[0].r});
        if (q0.size() == 0) check("flat_spurious", 64'(out_valid0), 64'(0));
        else if (out_valid0 && q0[0].chk) check("flat_data", {out_l0, out_r0}, {q0[0].l, q0[0].r});
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [19:0] ov1;
        logic [19:0] ov0;
        n_cmp = 0;
        n_bad = 0;
        acc1  = 0;
        acc0  = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 48'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", {out_l, out_r}, 64'h0);
        check("rst_out_valid_flat", 64'(out_valid0), 64'(0));
        check("rst_out_data_flat", {out_l0, out_r0}, 64'h0);
`ifdef DES_ROUND_PARITY_EN
        check("rst_err", 64'(err), 64'(0));
`endif
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_in_ready_flat", 64'(in_ready0), 64'(1));

        // Known answer, middle round
        @(negedge clk);
        drive(1'b1, 32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("kat_mid_lat1", 64'(out_valid), 64'(0));
        check("kat_flat_valid", 64'(out_valid0), 64'(1));
        check("kat_flat_data", {out_l0, out_r0}, 64'hF0AAF0AA_EF4A6544);
        @(negedge clk);
        check("kat_mid_valid", 64'(out_valid), 64'(1));
        check("kat_mid_data", {out_l, out_r}, 64'hF0AAF0AA_EF4A6544);
        check("kat_flat_drained", 64'(out_valid0), 64'(0));

        // Known answer, last round
        drive(1'b1, 32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("last_flat_data", {out_l0, out_r0}, 64'hEF4A6544_F0AAF0AA);
        @(negedge clk);
        check("last_mid_valid", 64'(out_valid), 64'(1));
        check("last_mid_data", {out_l, out_r}, 64'hEF4A6544_F0AAF0AA);

        // Streaming: 16 back-to-back blocks, outputs must come out with no gaps
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ov1[i] = out_valid;
            ov0[i] = out_valid0;
            if (i < 16) drive_rand();
            else in_valid = 1'b0;
        end
        check("stream_mid_pattern", 64'(ov1), 64'(20'h3FFFC));
        check("stream_flat_pattern", 64'(ov0), 64'(20'h1FFFE));

        // Backpressure: out_ready low for 5 cycles with a source that always has data
        @(negedge clk);
        acc1 = 0;
        acc0 = 0;
        out_ready = 1'b0;
        drive_rand();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (took1) drive_rand();
        end
        check("bp_mid_accepts", 64'(acc1), 64'(2));
        check("bp_flat_accepts", 64'(acc0), 64'(1));
        check("bp_mid_in_ready", 64'(in_ready), 64'(0));
        check("bp_mid_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < 10 && (q1.size() != 0 || q0.size() != 0); c++) @(negedge clk);
        check("bp_drain_mid", 64'(q1.size()), 64'(0));
        check("bp_drain_flat", 64'(q0.size()), 64'(0));

        // Reset with two blocks in flight
        out_ready = 1'b0;
        drive_rand();
        @(negedge clk);
        drive_rand();
        @(negedge clk);
        check("mid_two_in_flight", 64'(q1.size()), 64'(2));
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("rst_mid_flush", 64'(out_valid), 64'(0));
        check("rst_flat_flush", 64'(out_valid0), 64'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_mid_ready", 64'(in_ready), 64'(1));
        repeat (4) @(negedge clk);
        check("rst_no_stale", 64'(out_valid), 64'(0));

`ifdef DES_ROUND_PARITY_EN
        // Corrupt stored x of the block sitting in stage A
        drive_rand();
        @(negedge clk);
        in_valid = 1'b0;
        x_flip = dut.g_mid.x_a ^ 48'h0000_0000_0001;
        force dut.g_mid.x_a = x_flip;
        q1[0].chk = 1'b0;
        check("par_err_before", 64'(err), 64'(0));
        @(posedge clk);
        #1;
        release dut.g_mid.x_a;
        @(negedge clk);
        check("par_out_valid", 64'(out_valid), 64'(1));
        check("par_err_set", 64'(err), 64'(1));
        drive_rand();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("par_err_sticky", 64'(err), 64'(1));
        check("par_flat_err", 64'(err0), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("par_err_rst", 64'(err), 64'(0));
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
